// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the two requester ports (instruction fetch, load/store), the
//   unified memory port and the grant/busy status of mem_port_arbiter.
//   slave  : arbiter side (takes requests and mem_rdata, drives acks and memory)
//   master : environment side (requesters plus memory)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req;
  logic              dm_wr;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        grant;
  logic              busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata, mem_addr, mem_wr, mem_wdata,
           grant, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata, mem_addr, mem_wr, mem_wdata,
           grant, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between instruction fetch (IF) and
//   load/store (DM). A request seen in IDLE is latched, the memory is driven
//   for MEM_LAT cycles (loads) or one strobe cycle (stores), then the winner
//   gets a one-cycle ack.
// Ports
//   clock  : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : mem_port_arbiter_if.slave (IF/DM request ports, memory port,
//            grant 01=IF / 10=DM / 00=idle, busy)
// Parameters
//   ADDR_W, DATA_W : bus widths
//   MEM_LAT        : cycles from mem_addr to valid mem_rdata, >= 1
// Build option
//   ARB_RR_EN : defined -> ties alternate between IF and DM (last winner
//               loses); undefined -> fixed priority, DM beats IF.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

  generate
    if (MEM_LAT < 1) begin : g_lat_chk
      $error("mem_port_arbiter: MEM_LAT must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [1:0]        grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rd_q, if_rd_d;
  logic [DATA_W-1:0] dm_rd_q, dm_rd_d;
  logic              pick_dm;

`ifdef ARB_RR_EN
  // 1 = DM won the last arbitration; reset value favours DM on the first tie.
  logic last_dm_q, last_dm_d;
  assign pick_dm = bus.dm_req & (~bus.if_req | ~last_dm_q);
`else
  assign pick_dm = bus.dm_req;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if_rd_d = if_rd_q;
    dm_rd_d = dm_rd_q;
`ifdef ARB_RR_EN
    last_dm_d = last_dm_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.if_req | bus.dm_req) begin
          state_d = ACCESS;
          cnt_d   = '0;
          if (pick_dm) begin
            grant_d = 2'b10;
            addr_d  = bus.dm_addr;
            wdata_d = bus.dm_wdata;
            wr_d    = bus.dm_wr;
          end else begin
            grant_d = 2'b01;
            addr_d  = bus.if_addr;
            wdata_d = '0;
            wr_d    = 1'b0;
          end
`ifdef ARB_RR_EN
          last_dm_d = pick_dm;
`endif
        end
      end
      ACCESS: begin
        if (wr_q) begin
          state_d = RESP;
        end else if (cnt_q == CNT_W'(MEM_LAT)) begin
          // Read data is valid exactly now; steer it to the owner only.
          if (grant_q[1]) dm_rd_d = bus.mem_rdata;
          else            if_rd_d = bus.mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      grant_q <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      if_rd_q <= '0;
      dm_rd_q <= '0;
`ifdef ARB_RR_EN
      last_dm_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      if_rd_q <= if_rd_d;
      dm_rd_q <= dm_rd_d;
`ifdef ARB_RR_EN
      last_dm_q <= last_dm_d;
`endif
    end
  end

  // A store spends exactly one cycle in ACCESS with cnt==0, so one strobe.
  assign bus.mem_wr    = (state_q == ACCESS) & wr_q & (cnt_q == '0);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_ack    = (state_q == RESP) & grant_q[0];
  assign bus.dm_ack    = (state_q == RESP) & grant_q[1];
  assign bus.if_rdata  = if_rd_q;
  assign bus.dm_rdata  = dm_rd_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int LAT   = 2;
  localparam int LAT_B = 5;
`ifdef ARB_RR_EN
  localparam int EXP_BURST = 6'b101010;
`else
  localparam int EXP_BURST = 6'b111000;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clock(clock), .reset(reset), .bus(a)
  );
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT_B)) dut_b (
    .clock(clock), .reset(reset), .bus(b)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wr_pulses = 0;
  int ack_cnt = 0;
  int order[$];
  bit mon_on = 0;

  // Memory: word array plus address history giving the fixed read latency.
  logic [31:0] mem [256];
  logic [31:0] ha [8];
  logic [31:0] hb [8];
  logic        ld_en = 1'b0;
  logic [7:0]  ld_a = 8'h0;
  logic [31:0] ld_d = 32'h0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (ld_en) mem[ld_a] <= ld_d;
    else if (a.mem_wr) mem[a.mem_addr[7:0]] <= a.mem_wdata;
    for (int i = 7; i > 0; i--) begin
      ha[i] <= ha[i-1];
      hb[i] <= hb[i-1];
    end
    ha[0] <= a.mem_addr;
    hb[0] <= b.mem_addr;
  end
  assign a.mem_rdata = mem[ha[LAT-1][7:0]];
  assign b.mem_rdata = mem[hb[LAT_B-1][7:0]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int code_of();
    int c = 0;
    foreach (order[i]) c = (c << 1) | order[i];
    return c;
  endfunction

  initial forever begin
    @(negedge clock);
    if (a.mem_wr) wr_pulses++;
    if (a.if_ack || a.dm_ack) ack_cnt++;
  end

  // Reference model: one transaction at a time. Accepted in cycle s (IDLE,
  // req seen), it owns the memory in cycles s+1..s+L, where L is 2 for a
  // store and MEM_LAT+2 for a load; ack and load data appear in cycle s+L.
  initial begin : model
    bit act, m_dm, m_wr, in_win, last_dm, rst_prev;
    int s, L;
    logic [31:0] m_addr, m_wdata, m_data, e_addr, e_if_rd, e_dm_rd;
    act = 0; last_dm = 0; rst_prev = 0; s = 0; L = 0;
    m_dm = 0; m_wr = 0; m_addr = 0; m_wdata = 0; m_data = 0;
    e_addr = 0; e_if_rd = 0; e_dm_rd = 0;
    forever begin
      @(negedge clock);
      if (rst_prev) begin
        act = 0; last_dm = 0; e_addr = 0; e_if_rd = 0; e_dm_rd = 0;
      end
      if (act && cyc > s + L) act = 0;
      if (!reset && !act && (a.if_req || a.dm_req)) begin
`ifdef ARB_RR_EN
        m_dm = a.dm_req && (!a.if_req || !last_dm);
`else
        m_dm = a.dm_req;
`endif
        last_dm = m_dm;
        m_wr    = m_dm && a.dm_wr;
        m_addr  = m_dm ? a.dm_addr : a.if_addr;
        m_wdata = a.dm_wdata;
        m_data  = mem[m_addr[7:0]];
        s = cyc;
        L = m_wr ? 2 : LAT + 2;
        act = 1;
      end
      in_win = act && cyc > s && cyc <= s + L;
      if (act && cyc == s + 1) e_addr = m_addr;
      if (act && cyc == s + L && !m_wr) begin
        if (m_dm) e_dm_rd = m_data;
        else      e_if_rd = m_data;
      end
      if (mon_on) begin
        chk("grant", a.grant, in_win ? (m_dm ? 32'd2 : 32'd1) : 32'd0);
        chk("busy", a.busy, in_win);
        chk("if_ack", a.if_ack, act && cyc == s + L && !m_dm);
        chk("dm_ack", a.dm_ack, act && cyc == s + L && m_dm);
        chk("mem_wr", a.mem_wr, act && m_wr && cyc == s + 1);
        chk("mem_addr", a.mem_addr, e_addr);
        chk("if_rdata", a.if_rdata, e_if_rd);
        chk("dm_rdata", a.dm_rdata, e_dm_rd);
        if (act && m_wr && cyc == s + 1) chk("mem_wdata", a.mem_wdata, m_wdata);
      end
      rst_prev = reset;
    end
  end

  // Requester: raise req, keep it high for n acks (back-to-back requests),
  // drop it at the edge after the last ack. lat = cycles to first ack.
  task automatic req(input bit is_dm, input int n, input bit wr,
                     input logic [31:0] addr, input logic [31:0] wdata, output int lat);
    int t0, k, w;
    @(posedge clock); #1;
    if (is_dm) begin
      a.dm_req = 1; a.dm_wr = wr; a.dm_addr = addr; a.dm_wdata = wdata;
    end else begin
      a.if_req = 1; a.if_addr = addr;
    end
    t0 = cyc; k = 0; w = 0; lat = -1;
    while (k < n && w < 300) begin
      @(negedge clock);
      w++;
      if (is_dm ? a.dm_ack : a.if_ack) begin
        if (k == 0) lat = cyc - t0;
        k++;
        order.push_back(is_dm ? 1 : 0);
      end
    end
    chk(is_dm ? "dm_ack_count" : "if_ack_count", k, n);
    @(posedge clock); #1;
    if (is_dm) a.dm_req = 0;
    else       a.if_req = 0;
  endtask

  logic [7:0]  pa [3] = '{8'h10, 8'h40, 8'h50};
  logic [31:0] pd [3] = '{32'hDEADBEEF, 32'hCAFEF00D, 32'h0BADC0DE};
  int lat_i, lat_d, wr0, ack0, t0, found, lat_b;

  initial begin
    a.if_req = 0; a.if_addr = 0; a.dm_req = 0; a.dm_wr = 0; a.dm_addr = 0; a.dm_wdata = 0;
    b.if_req = 0; b.if_addr = 0; b.dm_req = 0; b.dm_wr = 0; b.dm_addr = 0; b.dm_wdata = 0;
    ld_en = 1;
    for (int i = 0; i < 3; i++) begin
      ld_a = pa[i]; ld_d = pd[i];
      @(posedge clock); #1;
    end
    ld_en = 0;
    reset = 0;
    mon_on = 1;
    @(negedge clock);
    chk("rst_busy", a.busy, 0);
    chk("rst_grant", a.grant, 0);
    chk("rst_mem_addr", a.mem_addr, 0);
    chk("rst_if_rdata", a.if_rdata, 0);
    chk("rst_dm_ack", a.dm_ack, 0);

    // IF load from 0x10
    req(0, 1, 0, 32'h10, 32'h0, lat_i);
    chk("t1_lat", lat_i, 4);
    chk("t1_if_rdata", a.if_rdata, 32'hDEADBEEF);

    // DM store 0x1234 -> 0x20
    wr0 = wr_pulses;
    req(1, 1, 1, 32'h20, 32'h1234, lat_d);
    chk("t2_lat", lat_d, 2);
    chk("t2_strobes", wr_pulses - wr0, 1);
    chk("t2_mem", mem[8'h20], 32'h1234);
    chk("t2_if_rdata_kept", a.if_rdata, 32'hDEADBEEF);
    chk("t2_dm_rdata_kept", a.dm_rdata, 32'h0);

    // Reset in the second ACCESS cycle of an IF load
    @(posedge clock); #1;
    a.if_addr = 32'h40; a.if_req = 1;
    repeat (2) begin @(posedge clock); #1; end
    reset = 1; a.if_req = 0;
    ack0 = ack_cnt;
    @(posedge clock); #1;
    reset = 0;
    @(negedge clock);
    chk("t5_busy", a.busy, 0);
    chk("t5_grant", a.grant, 0);
    chk("t5_if_rdata", a.if_rdata, 0);
    chk("t5_mem_addr", a.mem_addr, 0);
    repeat (4) @(negedge clock);
    chk("t5_no_ack", ack_cnt - ack0, 0);

    // Simultaneous single requests: DM first, IF one bubble later
    order.delete();
    fork
      req(0, 1, 0, 32'h10, 32'h0, lat_i);
      req(1, 1, 0, 32'h20, 32'h0, lat_d);
    join
    chk("t3_order", code_of(), 2'b10);
    chk("t3_dm_lat", lat_d, 4);
    chk("t3_if_lat", lat_i, 9);
    chk("t3_dm_rdata", a.dm_rdata, 32'h1234);
    chk("t3_if_rdata", a.if_rdata, 32'hDEADBEEF);

    // Both requesters streaming three requests each
    order.delete();
    fork
      req(0, 3, 0, 32'h50, 32'h0, lat_i);
      req(1, 3, 0, 32'h40, 32'h0, lat_d);
    join
    chk("t4_order", code_of(), EXP_BURST);
    chk("t4_if_rdata", a.if_rdata, 32'h0BADC0DE);
    chk("t4_dm_rdata", a.dm_rdata, 32'hCAFEF00D);

    // MEM_LAT=5 instance: address change mid-access is ignored
    @(posedge clock); #1;
    b.dm_req = 1; b.dm_wr = 0; b.dm_addr = 32'h10;
    t0 = cyc;
    repeat (2) begin @(posedge clock); #1; end
    b.dm_addr = 32'h40;
    found = 0; lat_b = -1;
    for (int w = 0; w < 30 && found == 0; w++) begin
      @(negedge clock);
      if (b.dm_ack) begin found = 1; lat_b = cyc - t0; end
    end
    @(posedge clock); #1;
    b.dm_req = 0;
    chk("t6_acked", found, 1);
    chk("t6_lat", lat_b, 7);
    chk("t6_dm_rdata", b.dm_rdata, 32'hDEADBEEF);
    @(negedge clock);
    chk("t6_ack_one_cycle", b.dm_ack, 0);

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end
endmodule
